// File: rtl/cga_seq_pkg.sv
// rtl/cga_seq_pkg.sv - slot constants and arbiter state type for the CGA character sequencer
package cga_seq_pkg;

   localparam logic [4:0] SEQ_CRTC      = 5'd0;
   localparam logic [4:0] SEQ_CHAR      = 5'd3;
   localparam logic [4:0] SEQ_ATT       = 5'd7;
   localparam logic [4:0] SEQ_ROM       = 5'd8;
   localparam logic [4:0] SEQ_CPU0      = 5'd9;
   localparam logic [4:0] SEQ_CPU1      = 5'd20;
   localparam logic [4:0] SEQ_WRAP_HRES = 5'd15;
   localparam logic [4:0] SEQ_WRAP_LRES = 5'd31;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      WAIT  = 2'd2
   } arb_state_t;

endpackage

// File: rtl/cga_vram_arbiter.sv
// rtl/cga_vram_arbiter.sv - grants fixed-length CPU VRAM slots between display fetches
module cga_vram_arbiter
   import cga_seq_pkg::*;
#(
   parameter int CPU_SLOT_LEN = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic slot_start,
   input  logic cpu_req,
   input  logic cpu_wr,
   output logic vram_cpu_sel,
   output logic vram_we,
   output logic cpu_done
);

   localparam logic [2:0] LAST = 3'(CPU_SLOT_LEN - 1);

   arb_state_t state, state_d;
   logic [2:0] cnt, cnt_d;
   logic       wr_q, wr_d;
   logic       last_d;

   // Next-state: grant only from IDLE, so a held request cannot be regranted until it drops
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      wr_d    = wr_q;
      case (state)
         IDLE: begin
            if (slot_start && cpu_req) begin
               state_d = GRANT;
               cnt_d   = 3'd0;
               wr_d    = cpu_wr;
            end
         end
         GRANT: begin
            if (cnt == LAST) state_d = WAIT;
            else             cnt_d   = cnt + 3'd1;
         end
         WAIT: begin
            if (!cpu_req) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      last_d = (state_d == GRANT) && (cnt_d == LAST);
   end

   // State register; write strobe and done are registered so they align with the last grant cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= 3'd0;
         wr_q     <= 1'b0;
         vram_we  <= 1'b0;
         cpu_done <= 1'b0;
      end else begin
         state    <= state_d;
         cnt      <= cnt_d;
         wr_q     <= wr_d;
         vram_we  <= last_d && wr_d;
         cpu_done <= last_d;
      end
   end

   assign vram_cpu_sel = (state == GRANT);

endmodule

// File: rtl/cga_sequencer.sv
// rtl/cga_sequencer.sv - character-clock phase counter, fetch strobes and CPU slot arbitration (option: CGA_SNOW_EN)
module cga_sequencer
   import cga_seq_pkg::*;
#(
   parameter int CPU_SLOT_LEN = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       hres_mode,
   input  logic       grph_mode,
   input  logic       display_enable,
   input  logic       cpu_req,
   input  logic       cpu_wr,
   output logic [4:0] clk_seq,
   output logic       crtc_clk,
   output logic       vram_read,
   output logic       vram_read_char,
   output logic       vram_read_att,
   output logic       charrom_read,
   output logic       disp_pipeline,
   output logic       vram_cpu_sel,
   output logic       vram_we,
   output logic       cpu_done
);

   logic       hres_l;
   logic       wrap;
   logic [4:0] seq_next;
   logic       slot_start;
   logic       snow_char;

   // Strobes are decoded from the next phase so the registered outputs line up with clk_seq
   always_comb begin
      wrap       = (clk_seq == (hres_l ? SEQ_WRAP_HRES : SEQ_WRAP_LRES));
      seq_next   = wrap ? 5'd0 : clk_seq + 5'd1;
      slot_start = (seq_next == SEQ_CPU0) || (!hres_l && (seq_next == SEQ_CPU1));
   end

`ifdef CGA_SNOW_EN
   // CPU byte on the bus gets latched as a character during hres text: reproduces snow
   assign snow_char = vram_cpu_sel && hres_l && !grph_mode && display_enable &&
                      (seq_next == SEQ_CPU0 + 5'd1);
`else
   logic unused_snow_inputs;
   assign unused_snow_inputs = grph_mode ^ display_enable;
   assign snow_char = 1'b0;
`endif

   // Phase counter, mode latch and registered fetch strobes
   always_ff @(posedge clk) begin
      if (reset) begin
         clk_seq        <= 5'd0;
         hres_l         <= 1'b0;
         crtc_clk       <= 1'b0;
         vram_read      <= 1'b0;
         vram_read_char <= 1'b0;
         vram_read_att  <= 1'b0;
         charrom_read   <= 1'b0;
         disp_pipeline  <= 1'b0;
      end else begin
         clk_seq        <= seq_next;
         if (wrap) hres_l <= hres_mode;
         crtc_clk       <= (seq_next == SEQ_CRTC);
         vram_read      <= (seq_next <= SEQ_ROM);
         vram_read_char <= (seq_next == SEQ_CHAR) || snow_char;
         vram_read_att  <= (seq_next == SEQ_ATT);
         charrom_read   <= (seq_next == SEQ_ROM);
         disp_pipeline  <= (seq_next == SEQ_CRTC);
      end
   end

   cga_vram_arbiter #(
      .CPU_SLOT_LEN (CPU_SLOT_LEN)
   ) u_arbiter (
      .clk          (clk),
      .reset        (reset),
      .slot_start   (slot_start),
      .cpu_req      (cpu_req),
      .cpu_wr       (cpu_wr),
      .vram_cpu_sel (vram_cpu_sel),
      .vram_we      (vram_we),
      .cpu_done     (cpu_done)
   );

endmodule

// File: tb/tb_cga_sequencer.sv
// tb/tb_cga_sequencer.sv - self-checking bench for cga_sequencer
module tb_cga_sequencer;

   localparam int LEN = 4;

   logic       clk = 1'b0;
   logic       reset, hres_mode, grph_mode, display_enable, cpu_req, cpu_wr;
   logic [4:0] clk_seq;
   logic       crtc_clk, vram_read, vram_read_char, vram_read_att, charrom_read;
   logic       disp_pipeline, vram_cpu_sel, vram_we, cpu_done;

   always #5 clk = ~clk;

   cga_sequencer #(.CPU_SLOT_LEN(LEN)) dut (
      .clk(clk), .reset(reset), .hres_mode(hres_mode), .grph_mode(grph_mode),
      .display_enable(display_enable), .cpu_req(cpu_req), .cpu_wr(cpu_wr),
      .clk_seq(clk_seq), .crtc_clk(crtc_clk), .vram_read(vram_read),
      .vram_read_char(vram_read_char), .vram_read_att(vram_read_att),
      .charrom_read(charrom_read), .disp_pipeline(disp_pipeline),
      .vram_cpu_sel(vram_cpu_sel), .vram_we(vram_we), .cpu_done(cpu_done)
   );

   int checks = 0;
   int errors = 0;
   bit chk_en = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: phase, latched mode, remaining grant cycles, blocked-until-drop flag
   int m_seq, m_wrapv, m_nseq, m_left;
   bit m_hl, m_rst, m_blocked, m_wr, m_snow, m_slot;

   always @(posedge clk) begin
      if (reset) begin
         m_seq = 0; m_hl = 0; m_rst = 1; m_left = 0; m_blocked = 0; m_wr = 0; m_snow = 0;
      end else begin
         m_wrapv = m_hl ? 15 : 31;
         m_nseq  = (m_seq == m_wrapv) ? 0 : m_seq + 1;
         m_slot  = (m_nseq == 9) || (!m_hl && m_nseq == 20);
         m_snow  = 0;
`ifdef CGA_SNOW_EN
         if (m_left > 0 && m_hl && !grph_mode && display_enable && m_nseq == 10) m_snow = 1;
`endif
         if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0) m_blocked = 1;
         end else if (m_blocked) begin
            if (!cpu_req) m_blocked = 0;
         end else if (m_slot && cpu_req) begin
            m_left = LEN;
            m_wr   = cpu_wr;
         end
         if (m_seq == m_wrapv) m_hl = hres_mode;
         m_seq = m_nseq;
         m_rst = 0;
      end
   end

   // Per-cycle comparison of every output against the model
   always @(negedge clk) begin
      if (chk_en) begin
         chk("clk_seq", clk_seq, m_seq);
         chk("crtc_clk", crtc_clk, !m_rst && m_seq == 0);
         chk("disp_pipeline", disp_pipeline, !m_rst && m_seq == 0);
         chk("vram_read_char", vram_read_char, !m_rst && (m_seq == 3 || m_snow));
         chk("vram_read_att", vram_read_att, !m_rst && m_seq == 7);
         chk("charrom_read", charrom_read, !m_rst && m_seq == 8);
         chk("vram_read", vram_read, !m_rst && m_seq <= 8);
         chk("vram_cpu_sel", vram_cpu_sel, m_left > 0);
         chk("cpu_done", cpu_done, m_left == 1);
         chk("vram_we", vram_we, m_left == 1 && m_wr);
         chk("bus_exclusive", vram_read & vram_cpu_sel, 0);
      end
   end

   task automatic wait_seq(input int v);
      bit f = 0;
      for (int i = 0; i < 64 && !f; i++) begin
         @(negedge clk);
         if (clk_seq == 5'(v)) f = 1;
      end
      chk("wait_seq_timeout", f, 1);
   endtask

   // Waits for the next grant, returns clk_seq at its first cycle and at cpu_done
   task automatic grant_window(output int s_rise, output int s_done, output int we_at_done);
      bit seen = 0;
      bit fin  = 0;
      s_rise = -1; s_done = -1; we_at_done = -1;
      for (int i = 0; i < 80 && !fin; i++) begin
         @(negedge clk);
         if (vram_cpu_sel && !seen) begin seen = 1; s_rise = int'(clk_seq); end
         if (cpu_done) begin fin = 1; s_done = int'(clk_seq); we_at_done = int'(vram_we); end
      end
   endtask

   int r, d, w, ndone;

   initial begin
      reset = 1; hres_mode = 1; grph_mode = 0; display_enable = 1; cpu_req = 0; cpu_wr = 0;
      @(posedge clk);
      chk_en = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_seq", clk_seq, 0);
      chk("rst_crtc", crtc_clk, 0);
      reset = 0;

      // First character uses reset latch (lowres), then hres takes over
      wait_seq(31);
      @(negedge clk);
      chk("first_wrap_crtc", crtc_clk, 1);
      wait_seq(15);
      @(negedge clk);
      chk("hres_wrap", clk_seq, 0);

      // Mode change mid-character takes effect at the next character
      wait_seq(5);
      hres_mode = 0;
      wait_seq(15);
      @(negedge clk);
      chk("toggle_wrap15", clk_seq, 0);
      wait_seq(31);
      @(negedge clk);
      chk("toggle_wrap31", clk_seq, 0);

      // Lowres write request after the first slot: granted at 20
      wait_seq(10);
      cpu_req = 1; cpu_wr = 1;
      grant_window(r, d, w);
      chk("lres_rise", r, 20);
      chk("lres_done", d, 23);
      chk("lres_we", w, 1);
      cpu_req = 0; cpu_wr = 0;

      // Hres held request: single done, regrant at next 9 after drop
      hres_mode = 1;
      wait_seq(31);
      wait_seq(2);
      cpu_req = 1;
      ndone = 0;
      for (int i = 0; i < 48; i++) begin
         @(negedge clk);
         if (cpu_done) ndone++;
      end
      chk("held_done_count", ndone, 1);
      cpu_req = 0;
      @(negedge clk);
      grph_mode = 1;
      cpu_req = 1;
      grant_window(r, d, w);
      chk("regrant_rise", r, 9);
      chk("regrant_done", d, 12);
      chk("regrant_we", w, 0);
      cpu_req = 0; grph_mode = 0;

      // Reset mid-grant aborts without done, arbiter back to IDLE
      wait_seq(2);
      cpu_req = 1; cpu_wr = 1;
      wait_seq(11);
      chk("pre_rst_sel", vram_cpu_sel, 1);
      reset = 1;
      @(negedge clk);
      chk("abort_sel", vram_cpu_sel, 0);
      chk("abort_we", vram_we, 0);
      chk("abort_done", cpu_done, 0);
      @(negedge clk);
      reset = 0;
      grant_window(r, d, w);
      chk("post_rst_rise", r, 9);
      chk("post_rst_done", d, 12);
      cpu_req = 0; cpu_wr = 0;
      repeat (8) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
